// File: rtl/pc_axi_write_master.sv
// pc_axi_write_master: buffers producer beats in a FIFO and drains them as one AXI4 INCR write burst per address strobe.
module pc_axi_write_master #(
  parameter int AXI_DATA_WIDTH = 512,
  parameter int AXI_ADDR_WIDTH = 64,
  parameter int FIFO_DEPTH     = 8,
  parameter int AXI_ID_WIDTH   = 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [AXI_DATA_WIDTH-1:0]   pc_st_data,
  input  logic                        pc_st_data_v,
  input  logic [AXI_ADDR_WIDTH-1:0]   pc_st_addr,
  input  logic                        pc_st_addr_v,
  output logic                        pc_awready,
  output logic                        pc_wready,
  output logic                        pc_bvalid,
  output logic                        err_overflow,
  output logic                        err_bresp,
  output logic                        err_empty,
  output logic [AXI_ID_WIDTH-1:0]     m_awid,
  output logic [AXI_ADDR_WIDTH-1:0]   m_awaddr,
  output logic [7:0]                  m_awlen,
  output logic [2:0]                  m_awsize,
  output logic [1:0]                  m_awburst,
  output logic                        m_awvalid,
  input  logic                        m_awready,
  output logic [AXI_DATA_WIDTH-1:0]   m_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_wstrb,
  output logic                        m_wlast,
  output logic                        m_wvalid,
  input  logic                        m_wready,
  input  logic [1:0]                  m_bresp,
  input  logic                        m_bvalid,
  output logic                        m_bready
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int SW = AXI_DATA_WIDTH / 8;
  localparam logic [2:0] SIZE = 3'($clog2(SW));
  typedef enum logic [2:0] {ST_IDLE, ST_AW, ST_W, ST_B, ST_DONE} state_t;
  state_t                    state_q;
  logic [AXI_DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]             wr_q, rd_q;
  logic [PW:0]               count_q, len_d;
  logic [AXI_ADDR_WIDTH-1:0] awaddr_q;
  logic [7:0]                awlen_q, beat_q;
  logic                      pc_bvalid_q, err_overflow_q, err_bresp_q, err_empty_q;
  logic                      full, push, pop;
  assign full  = count_q == (PW+1)'(FIFO_DEPTH);
  assign push  = pc_st_data_v && !full;
  assign pop   = m_wvalid && m_wready;
  // The burst length snapshot counts a beat pushed in the strobe cycle.
  assign len_d = count_q + (PW+1)'(push);
  always_ff @(posedge clk)
    if (push) mem_q[wr_q] <= pc_st_data;
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q        <= ST_IDLE;
      wr_q           <= '0;
      rd_q           <= '0;
      count_q        <= '0;
      awaddr_q       <= '0;
      awlen_q        <= '0;
      beat_q         <= '0;
      pc_bvalid_q    <= 1'b0;
      err_overflow_q <= 1'b0;
      err_bresp_q    <= 1'b0;
      err_empty_q    <= 1'b0;
    end else begin
      wr_q           <= wr_q + PW'(push);
      rd_q           <= rd_q + PW'(pop);
      count_q        <= count_q + (PW+1)'(push) - (PW+1)'(pop);
      err_overflow_q <= err_overflow_q | (pc_st_data_v & full);
      pc_bvalid_q    <= state_q == ST_DONE;
      case (state_q)
        ST_IDLE: if (pc_st_addr_v) begin
          awaddr_q <= pc_st_addr;
          awlen_q  <= 8'(len_d) - 8'd1;
          beat_q   <= '0;
          if (len_d == '0) begin
            err_empty_q <= 1'b1;
            state_q     <= ST_DONE;
          end else state_q <= ST_AW;
        end
        ST_AW: if (m_awready) state_q <= ST_W;
        ST_W: if (pop) begin
          beat_q <= beat_q + 8'd1;
          if (m_wlast) state_q <= ST_B;
        end
        ST_B: if (m_bvalid) begin
          err_bresp_q <= err_bresp_q | (m_bresp != 2'b00);
          state_q     <= ST_DONE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  assign pc_awready   = state_q == ST_IDLE;
  assign pc_wready    = !full;
  assign pc_bvalid    = pc_bvalid_q;
  assign err_overflow = err_overflow_q;
  assign err_bresp    = err_bresp_q;
  assign err_empty    = err_empty_q;
  assign m_awid       = '0;
  assign m_awaddr     = awaddr_q;
  assign m_awlen      = awlen_q;
  assign m_awvalid    = state_q == ST_AW;
  assign m_awsize     = m_awvalid ? SIZE : 3'd0;
  assign m_awburst    = m_awvalid ? 2'b01 : 2'b00;
  assign m_wvalid     = state_q == ST_W;
  assign m_wdata      = m_wvalid ? mem_q[rd_q] : '0;
  assign m_wstrb      = {SW{m_wvalid}};
  assign m_wlast      = m_wvalid && (beat_q == awlen_q);
  assign m_bready     = state_q == ST_B;
endmodule

// File: tb/tb_pc_axi_write_master.sv
// tb_pc_axi_write_master: directed burst table plus hand sequences for empty-strobe timing and mid-burst reset.
module tb_pc_axi_write_master;
  logic         clk = 1'b0, reset = 1'b0;
  logic [511:0] pc_st_data = '0;
  logic         pc_st_data_v = 1'b0;
  logic [63:0]  pc_st_addr = '0;
  logic         pc_st_addr_v = 1'b0;
  logic         pc_awready, pc_wready, pc_bvalid, err_overflow, err_bresp, err_empty;
  logic [0:0]   m_awid;
  logic [63:0]  m_awaddr;
  logic [7:0]   m_awlen;
  logic [2:0]   m_awsize;
  logic [1:0]   m_awburst;
  logic         m_awvalid, m_awready;
  logic [511:0] m_wdata;
  logic [63:0]  m_wstrb;
  logic         m_wlast, m_wvalid, m_wready;
  logic [1:0]   m_bresp;
  logic         m_bvalid, m_bready;

  pc_axi_write_master dut (
    .clk(clk), .reset(reset),
    .pc_st_data(pc_st_data), .pc_st_data_v(pc_st_data_v),
    .pc_st_addr(pc_st_addr), .pc_st_addr_v(pc_st_addr_v),
    .pc_awready(pc_awready), .pc_wready(pc_wready), .pc_bvalid(pc_bvalid),
    .err_overflow(err_overflow), .err_bresp(err_bresp), .err_empty(err_empty),
    .m_awid(m_awid), .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst), .m_awvalid(m_awvalid), .m_awready(m_awready),
    .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wlast(m_wlast), .m_wvalid(m_wvalid),
    .m_wready(m_wready), .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready)
  );

  initial forever #5 clk = ~clk;

  int total = 0, bad = 0;
  int aw_delay = 0, aw_cnt = 0;
  bit w_toggle = 1'b0;
  logic [1:0] bresp_cfg = 2'b00;

  // Slave model: updates its handshake inputs just after each rising edge.
  initial begin
    m_awready = 1'b0; m_wready = 1'b1; m_bvalid = 1'b0; m_bresp = 2'b00;
    forever begin
      @(posedge clk); #1;
      aw_cnt    = m_awvalid ? aw_cnt + 1 : 0;
      m_awready = m_awvalid && aw_cnt > aw_delay;
      m_wready  = w_toggle ? ~m_wready : 1'b1;
      m_bvalid  = m_bready;
      m_bresp   = m_bready ? bresp_cfg : 2'b00;
    end
  end

  logic [63:0]  awq_addr[$];
  logic [7:0]   awq_len[$];
  logic [2:0]   awq_size[$];
  logic [511:0] wq[$];
  bit           wl[$];
  int bv_n = 0, early_w = 0, hold_bad = 0, aw_bad = 0;
  bit aw_done = 0, aw_pend = 0, w_pend = 0;
  logic [63:0]  aw_addr_p;
  logic [7:0]   aw_len_p;
  logic [511:0] w_data_p;

  // Monitor: samples the bus mid-cycle, when everything the next edge sees is settled.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      aw_done = 0; aw_pend = 0; w_pend = 0;
    end else begin
      if (m_wvalid && !aw_done) early_w++;
      if (m_awvalid && aw_pend && (m_awaddr != aw_addr_p || m_awlen != aw_len_p)) aw_bad++;
      aw_pend = m_awvalid && !m_awready; aw_addr_p = m_awaddr; aw_len_p = m_awlen;
      if (m_awvalid && m_awready) begin
        awq_addr.push_back(m_awaddr); awq_len.push_back(m_awlen); awq_size.push_back(m_awsize);
        aw_done = 1;
      end
      if (m_wvalid && w_pend && m_wdata != w_data_p) hold_bad++;
      w_pend = m_wvalid && !m_wready; w_data_p = m_wdata;
      if (m_wvalid && m_wready) begin
        wq.push_back(m_wdata); wl.push_back(m_wlast);
        if (m_wlast) aw_done = 0;
      end
      if (pc_bvalid) bv_n++;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [511:0] beat(input int t);
    return {16{32'hA5A5_0000 + 32'(t)}};
  endfunction

  typedef struct {
    int n; logic [63:0] addr; int awd; bit tog; logic [1:0] resp;
    int exp_aw; int exp_len; int exp_beats; bit e_ovf; bit e_bresp; bit e_empty;
  } vec_t;

  task automatic run_row(input vec_t v, input int tag);
    int aw0 = awq_addr.size(), w0 = wq.size(), bv0 = bv_n;
    int e0 = early_w, h0 = hold_bad, a0 = aw_bad, c = 0, dm = 0, lm = 0;
    aw_delay = v.awd; w_toggle = v.tog; bresp_cfg = v.resp;
    @(posedge clk); #1;
    for (int i = 0; i < v.n; i++) begin
      pc_st_data = beat(tag + i); pc_st_data_v = 1'b1;
      @(posedge clk); #1;
    end
    pc_st_data_v = 1'b0; pc_st_addr = v.addr; pc_st_addr_v = 1'b1;
    @(posedge clk); #1;
    pc_st_addr_v = 1'b0;
    @(negedge clk);
    chk($sformatf("awvalid_lat[%0d]", tag), m_awvalid, 64'(v.exp_aw));
    while (bv_n == bv0 && c < 200) begin @(negedge clk); c++; end
    chk($sformatf("done_timeout[%0d]", tag), 64'(c < 200), 1);
    repeat (3) @(negedge clk);
    chk($sformatf("bvalid_pulses[%0d]", tag), 64'(bv_n - bv0), 1);
    chk($sformatf("aw_count[%0d]", tag), 64'(awq_addr.size() - aw0), 64'(v.exp_aw));
    if (awq_addr.size() > aw0) begin
      chk($sformatf("awaddr[%0d]", tag), awq_addr[aw0], v.addr);
      chk($sformatf("awlen[%0d]", tag), 64'(awq_len[aw0]), 64'(v.exp_len));
      chk($sformatf("awsize[%0d]", tag), 64'(awq_size[aw0]), 6);
    end
    chk($sformatf("w_beats[%0d]", tag), 64'(wq.size() - w0), 64'(v.exp_beats));
    for (int i = 0; i < v.exp_beats && w0 + i < wq.size(); i++) begin
      if (wq[w0 + i] != beat(tag + i)) dm++;
      if (wl[w0 + i] != (i == v.exp_beats - 1)) lm++;
    end
    chk($sformatf("wdata_order[%0d]", tag), 64'(dm), 0);
    chk($sformatf("wlast_pos[%0d]", tag), 64'(lm), 0);
    chk($sformatf("w_before_aw[%0d]", tag), 64'(early_w - e0), 0);
    chk($sformatf("w_hold[%0d]", tag), 64'(hold_bad - h0), 0);
    chk($sformatf("aw_stable[%0d]", tag), 64'(aw_bad - a0), 0);
    chk($sformatf("err_flags[%0d]", tag), {61'd0, err_overflow, err_bresp, err_empty},
        {61'd0, v.e_ovf, v.e_bresp, v.e_empty});
  endtask

  vec_t vecs[6];

  initial begin
    int w0, c, bv0;
    vecs[0] = '{6,  64'h1000, 0, 0, 2'b00, 1, 5, 6, 0, 0, 0};
    vecs[1] = '{6,  64'h2000, 4, 1, 2'b00, 1, 5, 6, 0, 0, 0};
    vecs[2] = '{0,  64'h3000, 0, 0, 2'b00, 0, 0, 0, 0, 0, 1};
    vecs[3] = '{10, 64'h4000, 0, 0, 2'b00, 1, 7, 8, 1, 0, 1};
    vecs[4] = '{6,  64'h5000, 0, 0, 2'b10, 1, 5, 6, 1, 1, 1};
    vecs[5] = '{3,  64'h6000, 0, 1, 2'b00, 1, 2, 3, 1, 1, 1};

    repeat (3) @(negedge clk);
    chk("rst_ready", {62'd0, pc_awready, pc_wready}, 3);
    chk("rst_valids", {60'd0, m_awvalid, m_wvalid, m_bready, pc_bvalid}, 0);
    chk("rst_errs", {61'd0, err_overflow, err_bresp, err_empty}, 0);
    chk("rst_aw", m_awaddr | 64'(m_awlen) | 64'(m_awsize) | 64'(m_awburst), 0);
    chk("rst_wstrb", m_wstrb, 0);
    @(posedge clk); #1 reset = 1'b1;

    for (int r = 0; r < 6; r++) run_row(vecs[r], r * 16);

    // Empty strobe: pulse lands two cycles after the strobe cycle.
    @(posedge clk); #1 pc_st_addr = 64'h7000; pc_st_addr_v = 1'b1;
    @(posedge clk); #1 pc_st_addr_v = 1'b0;
    @(negedge clk);
    chk("empty_c1", {61'd0, pc_bvalid, pc_awready, m_awvalid}, 0);
    @(negedge clk);
    chk("empty_c2", {61'd0, pc_bvalid, pc_awready, m_awvalid}, 6);
    @(negedge clk);
    chk("empty_c3", {61'd0, pc_bvalid, pc_awready, m_awvalid}, 2);

    // Reset in the middle of the W phase.
    aw_delay = 0; w_toggle = 0; bresp_cfg = 2'b00;
    w0 = wq.size(); bv0 = bv_n; c = 0;
    for (int i = 0; i < 6; i++) begin
      pc_st_data = beat(160 + i); pc_st_data_v = 1'b1;
      @(posedge clk); #1;
    end
    pc_st_data_v = 1'b0; pc_st_addr = 64'h8000; pc_st_addr_v = 1'b1;
    @(posedge clk); #1 pc_st_addr_v = 1'b0;
    while (wq.size() - w0 < 3 && c < 100) begin @(negedge clk); c++; end
    chk("rst_mid_reach", 64'(c < 100), 1);
    @(posedge clk); #2 reset = 1'b0;
    #1;
    chk("rst_mid_ready", {62'd0, pc_awready, pc_wready}, 3);
    chk("rst_mid_valids", {60'd0, m_awvalid, m_wvalid, m_bready, pc_bvalid}, 0);
    chk("rst_mid_errs", {61'd0, err_overflow, err_bresp, err_empty}, 0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_mid_no_bvalid", 64'(bv_n - bv0), 0);
    chk("rst_mid_beats", 64'(wq.size() - w0), 3);
    run_row('{4, 64'h9000, 0, 0, 2'b00, 1, 3, 4, 0, 0, 0}, 192);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
